// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the CPU SDRAM port to MiSTer DDRAM bridge.
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_ACK,
    RD_ISSUE,
    RD_WAIT,
    RD_ACK
  } bridge_state_t;

  localparam logic [7:0] BE_LO     = 8'h0F;
  localparam logic [7:0] BE_HI     = 8'hF0;
  localparam logic [7:0] BURST_ONE = 8'd1;

endpackage

// File: rtl/sdram_ddram_bridge_line_cache.sv
// Single 64-bit line buffer for the bridge: tag/valid/data, hit compare, half-word write update.
// Instantiated by sdram_ddram_bridge only when SDRAM_LINE_CACHE_EN is defined.
module sdram_line_cache
  import sdram_bridge_pkg::*;
(
  input  logic        clk1x,
  input  logic        reset,
  input  logic [20:0] tag_i,
  input  logic        hi_i,
  output logic        hit_o,
  output logic [31:0] hit_data_o,
  input  logic        fill_i,
  input  logic [20:0] fill_tag_i,
  input  logic [63:0] fill_data_i,
  input  logic        wr_i,
  input  logic [31:0] wr_data_i,
  input  logic        inval_i
);

  logic        valid_q, valid_d;
  logic [20:0] tag_q, tag_d;
  logic [63:0] line_q, line_d;

  assign hit_o      = valid_q && (tag_q == tag_i);
  assign hit_data_o = hi_i ? line_q[63:32] : line_q[31:0];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (wr_i && hit_o) begin
      if (hi_i) line_d[63:32] = wr_data_i;
      else      line_d[31:0]  = wr_data_i;
    end
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
      line_d  = fill_data_i;
    end
    if (inval_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk1x) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // NOTE: tag and line storage carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk1x) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

endmodule

// File: rtl/sdram_ddram_bridge.sv
// CPU 32-bit SDRAM-port responder issuing single-beat 64-bit MiSTer DDRAM transactions.
// Optional line buffer: define SDRAM_LINE_CACHE_EN.
module sdram_ddram_bridge
  import sdram_bridge_pkg::*;
#(
  parameter logic [28:0] DDR_BASE   = 29'h0600_0000,
  parameter int          RD_TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk1x,
  input  logic        reset,
  input  logic [21:0] sdram_addr,
  input  logic [31:0] sdram_data_in,
  output logic [31:0] sdram_data_out,
  input  logic        sdram_req,
  input  logic        sdram_write,
  output logic        sdram_ready,
  output logic        sdram_done,
  output logic        sdram_err,
  output logic        DDRAM_CLK,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  localparam int WD_W = $clog2(RD_TIMEOUT + 1);

  bridge_state_t   state_q, state_d;
  logic            ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic            rd_q, rd_d, we_q, we_d, hi_q, hi_d;
  logic [31:0]     dout_q, dout_d;
  logic [28:0]     ddr_addr_q, ddr_addr_d;
  logic [63:0]     din_q, din_d;
  logic [7:0]      be_q, be_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expired;
  logic            cache_hit;
  logic [31:0]     cache_word;

  assign wd_expired = (state_q == RD_WAIT) && !DDRAM_DOUT_READY && (wd_q == WD_W'(RD_TIMEOUT));

`ifdef SDRAM_LINE_CACHE_EN
  logic [20:0] tag_q;

  always_ff @(posedge clk1x) begin
    if (state_q == IDLE) tag_q <= sdram_addr[21:1];
  end

  sdram_line_cache u_line_cache (
    .clk1x       (clk1x),
    .reset       (reset),
    .tag_i       (sdram_addr[21:1]),
    .hi_i        (sdram_addr[0]),
    .hit_o       (cache_hit),
    .hit_data_o  (cache_word),
    .fill_i      ((state_q == RD_WAIT) && DDRAM_DOUT_READY),
    .fill_tag_i  (tag_q),
    .fill_data_i (DDRAM_DOUT),
    .wr_i        ((state_q == IDLE) && sdram_write),
    .wr_data_i   (sdram_data_in),
    .inval_i     (wd_expired)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
`endif

  // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    done_d     = done_q;
    err_d      = err_q;
    rd_d       = rd_q;
    we_d       = we_q;
    hi_d       = hi_q;
    dout_d     = dout_q;
    ddr_addr_d = ddr_addr_q;
    din_d      = din_q;
    be_d       = be_q;
    wd_d       = wd_q;

    if ((state_q == IDLE) && (sdram_write || sdram_req)) begin
      hi_d       = sdram_addr[0];
      ddr_addr_d = DDR_BASE + {8'b0, sdram_addr[21:1]};
      din_d      = {sdram_data_in, sdram_data_in};
      be_d       = sdram_addr[0] ? BE_HI : BE_LO;
    end

    unique case (state_q)
      IDLE: begin
        if (sdram_write) begin
          we_d    = 1'b1;
          state_d = WR_ISSUE;
        end else if (sdram_req) begin
          if (cache_hit) begin
            dout_d  = cache_word;
            ready_d = 1'b1;
            state_d = RD_ACK;
          end else begin
            rd_d    = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      WR_ISSUE: if (!DDRAM_BUSY) begin
        we_d    = 1'b0;
        done_d  = 1'b1;
        state_d = WR_ACK;
      end
      WR_ACK: if (!sdram_write) begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      RD_ISSUE: if (!DDRAM_BUSY) begin
        rd_d    = 1'b0;
        wd_d    = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          dout_d  = hi_q ? DDRAM_DOUT[63:32] : DDRAM_DOUT[31:0];
          ready_d = 1'b1;
          state_d = RD_ACK;
        end else if (wd_expired) begin
          dout_d  = ERR_DATA;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = RD_ACK;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RD_ACK: if (!sdram_req) begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1x) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      we_q       <= 1'b0;
      hi_q       <= 1'b0;
      dout_q     <= '0;
      ddr_addr_q <= '0;
      din_q      <= '0;
      be_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      hi_q       <= hi_d;
      dout_q     <= dout_d;
      ddr_addr_q <= ddr_addr_d;
      din_q      <= din_d;
      be_q       <= be_d;
      wd_q       <= wd_d;
    end
  end

  assign sdram_data_out = dout_q;
  assign sdram_ready    = ready_q;
  assign sdram_done     = done_q;
  assign sdram_err      = err_q;
  assign DDRAM_CLK      = clk1x;
  assign DDRAM_BURSTCNT = BURST_ONE;
  assign DDRAM_ADDR     = ddr_addr_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;

endmodule

// File: tb/tb_sdram_ddram_bridge.sv
// Directed bench for sdram_ddram_bridge with a DDRAM responder model (random BUSY, 5-20 cycle reads).
module tb_sdram_ddram_bridge;

  localparam logic [28:0] BASE = 29'h0600_0000;

  logic        clk1x = 1'b0;
  logic        reset;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_in, sdram_data_out;
  logic        sdram_req, sdram_write, sdram_ready, sdram_done, sdram_err;
  logic        DDRAM_CLK, DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT, DDRAM_DIN;

  sdram_ddram_bridge dut (
    .clk1x(clk1x), .reset(reset),
    .sdram_addr(sdram_addr), .sdram_data_in(sdram_data_in), .sdram_data_out(sdram_data_out),
    .sdram_req(sdram_req), .sdram_write(sdram_write), .sdram_ready(sdram_ready),
    .sdram_done(sdram_done), .sdram_err(sdram_err),
    .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  always #5 clk1x = ~clk1x;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Responder model state
  int          busy_mode = -1;
  bit          withhold = 1'b0;
  bit          late_beat = 1'b0;
  int          busy_left, rd_lat;
  bit          in_cmd, rd_pending;
  int          we_cnt = 0, rd_cnt = 0, unstable = 0;
  logic [28:0] last_addr, snap_addr;
  logic [7:0]  last_be, snap_be;
  logic [63:0] last_din, snap_din;
  logic [5:0]  rd_idx;
  logic [63:0] mem [64];
  time         acc_time, t_ready;

  initial begin
    logic [5:0] idx;
    for (int i = 0; i < 64; i++) mem[i] = {32'hF000_0000 | 32'(i), 32'hE000_0000 | 32'(i)};
    DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
    in_cmd = 1'b0; rd_pending = 1'b0; busy_left = 0; rd_lat = 0;
    forever begin
      @(negedge clk1x);
      DDRAM_DOUT_READY = 1'b0;
      if (late_beat) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = 64'h1111_2222_3333_4444;
        late_beat = 1'b0;
      end else if (rd_pending) begin
        if (rd_lat == 0) begin
          DDRAM_DOUT_READY = 1'b1;
          DDRAM_DOUT = mem[rd_idx];
          rd_pending = 1'b0;
        end else rd_lat--;
      end
      if (reset) begin
        in_cmd = 1'b0; rd_pending = 1'b0; DDRAM_BUSY = 1'b0;
      end else if (DDRAM_WE || DDRAM_RD) begin
        if (!in_cmd) begin
          in_cmd = 1'b1;
          busy_left = (busy_mode < 0) ? int'($urandom_range(0, 3)) : busy_mode;
          snap_addr = DDRAM_ADDR; snap_be = DDRAM_BE; snap_din = DDRAM_DIN;
        end else if (DDRAM_ADDR !== snap_addr || DDRAM_BE !== snap_be || DDRAM_DIN !== snap_din) begin
          unstable++;
        end
        if (busy_left > 0) begin
          DDRAM_BUSY = 1'b1;
          busy_left--;
        end else begin
          DDRAM_BUSY = 1'b0;
          in_cmd = 1'b0;
          acc_time = $time;
          idx = 6'(DDRAM_ADDR - BASE);
          if (DDRAM_WE) begin
            we_cnt++;
            last_addr = DDRAM_ADDR; last_be = DDRAM_BE; last_din = DDRAM_DIN;
            for (int b = 0; b < 8; b++) if (DDRAM_BE[b]) mem[idx][8*b +: 8] = DDRAM_DIN[8*b +: 8];
          end else begin
            rd_cnt++;
            if (!withhold) begin
              rd_pending = 1'b1;
              rd_lat = int'($urandom_range(5, 20));
              rd_idx = idx;
            end
          end
        end
      end else begin
        DDRAM_BUSY = 1'b0;
        in_cmd = 1'b0;
      end
    end
  end

  task automatic do_write(input logic [21:0] a, input logic [31:0] d,
                          input logic [28:0] exp_addr, input logic [7:0] exp_be, output int lat);
    int n, we0;
    we0 = we_cnt;
    sdram_addr = a; sdram_data_in = d; sdram_write = 1'b1;
    n = 0;
    do begin @(negedge clk1x); n++; end while (!sdram_done && n < 200);
    lat = n;
    check("wr_done", sdram_done, 1);
    check("wr_we_count", we_cnt - we0, 1);
    check("wr_addr", last_addr, exp_addr);
    check("wr_be", last_be, exp_be);
    check("wr_din", last_din, {d, d});
    sdram_write = 1'b0;
    @(negedge clk1x);
    check("wr_done_release", sdram_done, 0);
  endtask

  task automatic do_read(input logic [21:0] a, input logic [31:0] exp, output int lat, output int nrd);
    int n, rd0;
    rd0 = rd_cnt;
    sdram_addr = a; sdram_req = 1'b1;
    n = 0;
    do begin @(negedge clk1x); n++; end while (!sdram_ready && n < 300);
    lat = n;
    nrd = rd_cnt - rd0;
    check("rd_ready", sdram_ready, 1);
    check("rd_data", sdram_data_out, exp);
    sdram_req = 1'b0;
    @(negedge clk1x);
    check("rd_ready_release", sdram_ready, 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk1x);
    reset = 1'b1; sdram_req = 1'b0; sdram_write = 1'b0;
    @(negedge clk1x);
    check(tag, {sdram_ready, sdram_done, sdram_err, DDRAM_RD, DDRAM_WE, sdram_data_out}, 0);
    reset = 1'b0;
  endtask

  initial begin
    int lat, nrd, n, rd0, we0, u0;
    reset = 1'b1; sdram_req = 1'b0; sdram_write = 1'b0; sdram_addr = '0; sdram_data_in = '0;
    repeat (3) @(negedge clk1x);
    check("reset_outputs", {sdram_ready, sdram_done, sdram_err, DDRAM_RD, DDRAM_WE, sdram_data_out}, 0);
    check("burstcnt", DDRAM_BURSTCNT, 8'd1);
    reset = 1'b0;
    @(negedge clk1x);

    // Four writes; the first with BUSY never asserted to pin the 2-cycle latency.
    busy_mode = 0;
    do_write(22'd0, 32'o00000000, 29'h0600_0000, 8'h0F, lat);
    check("wr_latency", lat, 2);
    busy_mode = -1;
    do_write(22'd1, 32'o10101111, 29'h0600_0000, 8'hF0, lat);
    do_write(22'd2, 32'o20202222, 29'h0600_0001, 8'h0F, lat);
    do_write(22'd4, 32'o30303333, 29'h0600_0002, 8'h0F, lat);
    check("line0_both_halves", mem[0], {32'o10101111, 32'o00000000});

    do_read(22'd0, 32'o00000000, lat, nrd);
    do_read(22'd1, 32'o10101111, lat, nrd);
    do_read(22'd2, 32'o20202222, lat, nrd);
    do_read(22'd4, 32'o30303333, lat, nrd);

    // BUSY held 10 cycles while WE is up.
    busy_mode = 10;
    u0 = unstable;
    do_write(22'd12, 32'h5A5A_A5A5, 29'h0600_0006, 8'h0F, lat);
    check("busy_stable", unstable - u0, 0);
    check("busy_latency", lat, 12);
    busy_mode = -1;

    // req and write together: write first, then the read sees the new data.
    we0 = we_cnt; rd0 = rd_cnt;
    sdram_addr = 22'd6; sdram_data_in = 32'hCAFE_F00D; sdram_write = 1'b1; sdram_req = 1'b1;
    n = 0;
    while (!sdram_done && n < 200) begin @(negedge clk1x); n++; end
    check("both_done", sdram_done, 1);
    check("both_no_rd_yet", rd_cnt - rd0, 0);
    check("both_we", we_cnt - we0, 1);
    check("both_addr", last_addr, 29'h0600_0003);
    sdram_write = 1'b0;
    n = 0;
    while (!sdram_ready && n < 300) begin @(negedge clk1x); n++; end
    check("both_ready", sdram_ready, 1);
    check("both_data", sdram_data_out, 32'hCAFE_F00D);
    check("both_rd", rd_cnt - rd0, 1);
    sdram_req = 1'b0;
    @(negedge clk1x);

    // Top of the address window.
    do_write(22'h3F_FFFF, 32'h0BAD_F00D, 29'h061F_FFFF, 8'hF0, lat);
    do_read(22'h3F_FFFF, 32'h0BAD_F00D, lat, nrd);
    check("top_low_half", mem[63][31:0], 32'hE000_003F);
    check("err_clear_before_timeout", sdram_err, 0);

    // Read watchdog.
    withhold = 1'b1;
    rd0 = rd_cnt;
    sdram_addr = 22'd9; sdram_req = 1'b1;
    n = 0;
    while (rd_cnt == rd0 && n < 50) begin @(negedge clk1x); n++; end
    check("to_issued", rd_cnt - rd0, 1);
    n = 0;
    while (!sdram_ready && n < 400) begin @(negedge clk1x); n++; end
    t_ready = $time;
    check("to_ready", sdram_ready, 1);
    check("to_cycles", (t_ready - acc_time) / 10, 257);
    check("to_data", sdram_data_out, 32'hDEAD_BEEF);
    check("to_err", sdram_err, 1);
    late_beat = 1'b1;
    repeat (3) @(negedge clk1x);
    check("late_beat_data", sdram_data_out, 32'hDEAD_BEEF);
    check("late_beat_ready", sdram_ready, 1);
    sdram_req = 1'b0;
    @(negedge clk1x);
    check("to_release", sdram_ready, 0);
    late_beat = 1'b1;
    repeat (3) @(negedge clk1x);
    check("stray_beat_idle", sdram_ready, 0);
    withhold = 1'b0;
    do_read(22'd2, 32'o20202222, lat, nrd);
    check("err_sticky", sdram_err, 1);
    apply_reset("reset_clears_err");

`ifdef SDRAM_LINE_CACHE_EN
    do_read(22'd4, 32'o30303333, lat, nrd);
    check("cache_miss_rd", nrd, 1);
    do_read(22'd5, 32'hF000_0002, lat, nrd);
    check("cache_hit_rd", nrd, 0);
    check("cache_hit_latency", lat, 1);
    do_write(22'd5, 32'h7777_0005, 29'h0600_0002, 8'hF0, lat);
    do_read(22'd5, 32'h7777_0005, lat, nrd);
    check("cache_wr_update_rd", nrd, 0);
`endif

    // Reset while waiting for read data.
    withhold = 1'b1;
    rd0 = rd_cnt;
    sdram_addr = 22'd10; sdram_req = 1'b1;
    n = 0;
    while (rd_cnt == rd0 && n < 50) begin @(negedge clk1x); n++; end
    check("mid_issued", rd_cnt - rd0, 1);
    repeat (4) @(negedge clk1x);
    apply_reset("mid_reset_outputs");
    withhold = 1'b0;
    repeat (3) @(negedge clk1x);
    check("mid_idle", {sdram_ready, DDRAM_RD}, 0);
    do_read(22'd10, 32'hE000_0005, lat, nrd);
    check("post_reset_rd", nrd, 1);
`ifdef SDRAM_LINE_CACHE_EN
    do_read(22'd5, 32'h7777_0005, lat, nrd);
    check("cache_reset_invalid", nrd, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
